// File: rtl/uart_cmd_bridge_pkg.sv
// Shared types and constants for the UART-to-graphite command bridge.
package uart_cmd_pkg;
  localparam int CMD_BYTES = 4;
  localparam int CMD_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    PUSH = 2'd2
  } asm_state_e;
endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Command word stream from the bridge into graphite.
interface uart_cmd_bridge_if;
  import uart_cmd_pkg::*;

  // A word moves on any clk_pix edge with tvalid=1 and tready=1; once raised,
  // tvalid and tdata hold until that edge, and tvalid never looks at tready.
  logic             tvalid;
  logic             tready;
  logic [CMD_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_cmd_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
module cmd_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  push_data_i,
  output logic               full_o,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [LEVEL_W-1:0] level_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               pop_ok, push_ok, out_load, mem_empty, mem_wr;

  always_comb begin
    pop_ok    = valid_q & pop_i;
    push_ok   = push_i & (!full_o | pop_ok);
    out_load  = !valid_q | pop_ok;
    // level_q counts the output register too, so the RAM is empty when they match
    mem_empty = (level_q == LEVEL_W'(valid_q));
    valid_d   = valid_q;
    data_d    = data_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    mem_wr    = 1'b0;
    if (out_load) begin
      if (!mem_empty) begin
        valid_d  = 1'b1;
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else if (push_ok) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (push_ok && !(out_load && mem_empty)) begin
      mem_wr   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LEVEL_W'(push_ok) - LEVEL_W'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (level_q == LEVEL_W'(DEPTH));
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign level_o = level_q;
endmodule

// File: rtl/uart_cmd_bridge.sv
// Packs UART bytes big-endian into 32-bit command words, drops stale partial
// words after an idle timeout, and queues finished words towards graphite.
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int LEVEL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_pix,
  input  logic                     reset,
  input  logic [7:0]               uart_rx_data_i,
  input  logic                     uart_valid_i,
  input  logic                     uart_busy_i,
  output logic                     uart_rd_o,
  uart_cmd_bridge_if.master        cmd_axis,
  output logic [LEVEL_W-1:0]       fifo_level_o,
  output logic [1:0]               byte_phase_o,
  output logic                     err_timeout_o,
  output logic [7:0]               timeout_count_o,
  output asm_state_e               dbg_state_o
);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  asm_state_e       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CMD_W-1:0] asm_q, asm_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [31:0]      idle_cnt_q, idle_cnt_d;
  logic             push, fifo_full, accept, expire;

  always_comb begin
    accept = (state_q == IDLE) && uart_valid_i && !uart_busy_i && !fifo_full;
    // an arriving byte beats an expiry on the same edge
    expire = TO_EN && (state_q == IDLE) && (phase_q != 2'd0) && !accept &&
             (idle_cnt_q == TO_LAST);
    state_d    = state_q;
    phase_d    = phase_q;
    asm_d      = asm_q;
    rd_d       = 1'b0;
    err_d      = 1'b0;
    tcnt_d     = tcnt_q;
    idle_cnt_d = idle_cnt_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          asm_d[8*(CMD_BYTES-1-int'(phase_q)) +: 8] = uart_rx_data_i;
          rd_d       = 1'b1;
          idle_cnt_d = '0;
          state_d    = ACK;
        end else if (expire) begin
          phase_d    = 2'd0;
          asm_d      = '0;
          err_d      = 1'b1;
          tcnt_d     = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
          idle_cnt_d = '0;
        end else if (phase_q != 2'd0) begin
          idle_cnt_d = idle_cnt_q + 32'd1;
        end else begin
          idle_cnt_d = '0;
        end
      end
      ACK: begin
        phase_d = phase_q + 2'd1;
        state_d = (phase_q == 2'd3) ? PUSH : IDLE;
      end
      PUSH: begin
        push    = 1'b1;
        asm_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      asm_q      <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= 8'd0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  cmd_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (FIFO_DEPTH),
    .LEVEL_W(LEVEL_W)
  ) u_fifo (
    .clk_i      (clk_pix),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i(asm_q),
    .full_o     (fifo_full),
    .pop_i      (cmd_axis.tready),
    .valid_o    (cmd_axis.tvalid),
    .data_o     (cmd_axis.tdata),
    .level_o    (fifo_level_o)
  );

  assign uart_rd_o       = rd_q;
  assign byte_phase_o    = phase_q;
  assign err_timeout_o   = err_q;
  assign timeout_count_o = tcnt_q;
  assign dbg_state_o     = state_q;
endmodule
